median3x3_stream: RTL

Parametrised 3×3 median filter for the video pixel path. It includes its own line buffers, generic data width and line length, selectable border handling and a per-pixel bypass. It produces the exact median of nine samples, with hs/vs/de delayed by the same fixed latency. It sits between the pixel source (sensor/DMA stream) and downstream video processing, replacing the fixed 8-bit filter that depended on an external shift-register IP.

---
 rtl/median3x3_stream_if.sv | 30 +++
 rtl/median3x3_stream.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/median3x3_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : median3x3_stream_if
// Brief    : Pixel stream bundle (input pixel/syncs/bypass, output pixel/syncs)
// Revision : 1.0
// ============================================================================
interface median3x3_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_in_en;
  logic              hs_in;
  logic              vs_in;
  logic              bypass;
  logic [DATA_W-1:0] data_out;
  logic              data_out_en;
  logic              hs_out;
  logic              vs_out;

  modport master (
    output data_in, data_in_en, hs_in, vs_in, bypass,
    input  data_out, data_out_en, hs_out, vs_out
  );

  modport slave (
    input  data_in, data_in_en, hs_in, vs_in, bypass,
    output data_out, data_out_en, hs_out, vs_out
  );
endinterface
`default_nettype wire

// File: rtl/median3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : median3x3_stream
// Brief    : 3x3 streaming median filter with internal line buffers,
//            selectable border handling, per-pixel bypass, 4-clock latency
// Revision : 1.0
// ============================================================================
module median3x3_stream #(
  parameter int DATA_W      = 8,
  parameter int IMG_W       = 640,
  parameter int BORDER_MODE = 0
) (
  input wire                clk,
  input wire                rst_n,
  median3x3_stream_if.slave s
);

  localparam int                 c_COL_W    = $clog2(IMG_W);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
  localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
  localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);

  typedef logic [DATA_W-1:0] pix_t;

  function automatic pix_t f_max2(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic pix_t f_min2(input pix_t a, input pix_t b);
    return (a > b) ? b : a;
  endfunction

  function automatic pix_t f_max3(input pix_t a, input pix_t b, input pix_t c);
    return f_max2(f_max2(a, b), c);
  endfunction

  function automatic pix_t f_min3(input pix_t a, input pix_t b, input pix_t c);
    return f_min2(f_min2(a, b), c);
  endfunction

  function automatic pix_t f_med3(input pix_t a, input pix_t b, input pix_t c);
    return f_max2(f_min2(a, b), f_min2(f_max2(a, b), c));
  endfunction

  pix_t               r_line_a [IMG_W];
  pix_t               r_line_b [IMG_W];
  logic [c_COL_W-1:0] r_col;
  logic [1:0]         r_row;
  logic [3:0]         r_dly_de;
  logic [3:0]         r_dly_hs;
  logic [3:0]         r_dly_vs;
  pix_t               r_win [3][3];
  logic               r_byp0, r_bord0;
  pix_t               r_s1_max [3];
  pix_t               r_s1_mid [3];
  pix_t               r_s1_min [3];
  logic               r_byp1, r_bord1;
  pix_t               r_cen1;
  pix_t               r_s2_lo, r_s2_md, r_s2_hi;
  logic               r_byp2, r_bord2;
  pix_t               r_cen2;
  pix_t               r_data_out;

  pix_t w_rd_a, w_rd_b, w_median;
  logic w_line_end, w_frame_start, w_border;

  assign w_rd_a        = r_line_a[r_col];
  assign w_rd_b        = r_line_b[r_col];
  assign w_line_end    = r_dly_de[0] & ~s.data_in_en;
  assign w_frame_start = s.vs_in & ~r_dly_vs[0];
  assign w_border      = ~((r_row == 2'd2) && (r_col >= c_COL_TWO));
  assign w_median      = f_med3(r_s2_lo, r_s2_md, r_s2_hi);

  // Line A holds the previous line, line B the one before; contents survive reset.
  always_ff @(posedge clk) begin
    if (s.data_in_en) begin
      r_line_a[r_col] <= s.data_in;
      r_line_b[r_col] <= w_rd_a;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_row    <= '0;
      r_dly_de <= '0;
      r_dly_hs <= '0;
      r_dly_vs <= '0;
    end else begin
      r_dly_de <= {r_dly_de[2:0], s.data_in_en};
      r_dly_hs <= {r_dly_hs[2:0], s.hs_in};
      r_dly_vs <= {r_dly_vs[2:0], s.vs_in};
      if (w_frame_start) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_line_end) begin
        r_col <= '0;
        if (r_row != 2'd2) r_row <= r_row + 2'd1;
      end else if (s.data_in_en) begin
        r_col <= (r_col == c_COL_LAST) ? '0 : r_col + c_COL_ONE;
      end
    end
  end

  // Window row 0 is the current line, column 0 the newest sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) r_win[r][c] <= '0;
      end
      r_byp0 <= 1'b0;
      r_bord0 <= 1'b0;
    end else begin
      r_byp0  <= s.bypass;
      r_bord0 <= w_border;
      if (s.data_in_en) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][2] <= r_win[r][1];
          r_win[r][1] <= r_win[r][0];
        end
        r_win[0][0] <= s.data_in;
        r_win[1][0] <= w_rd_a;
        r_win[2][0] <= w_rd_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        r_s1_max[c] <= '0;
        r_s1_mid[c] <= '0;
        r_s1_min[c] <= '0;
      end
      r_byp1     <= 1'b0;
      r_bord1    <= 1'b0;
      r_cen1     <= '0;
      r_s2_lo    <= '0;
      r_s2_md    <= '0;
      r_s2_hi    <= '0;
      r_byp2     <= 1'b0;
      r_bord2    <= 1'b0;
      r_cen2     <= '0;
      r_data_out <= '0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        r_s1_max[c] <= f_max3(r_win[0][c], r_win[1][c], r_win[2][c]);
        r_s1_mid[c] <= f_med3(r_win[0][c], r_win[1][c], r_win[2][c]);
        r_s1_min[c] <= f_min3(r_win[0][c], r_win[1][c], r_win[2][c]);
      end
      r_byp1  <= r_byp0;
      r_bord1 <= r_bord0;
      r_cen1  <= r_win[1][1];

      r_s2_lo <= f_min3(r_s1_max[0], r_s1_max[1], r_s1_max[2]);
      r_s2_md <= f_med3(r_s1_mid[0], r_s1_mid[1], r_s1_mid[2]);
      r_s2_hi <= f_max3(r_s1_min[0], r_s1_min[1], r_s1_min[2]);
      r_byp2  <= r_byp1;
      r_bord2 <= r_bord1;
      r_cen2  <= r_cen1;

      if (r_byp2)       r_data_out <= r_cen2;
      else if (r_bord2) r_data_out <= (BORDER_MODE != 0) ? '0 : r_cen2;
      else              r_data_out <= w_median;
    end
  end

  assign s.data_out    = r_data_out;
  assign s.data_out_en = r_dly_de[3];
  assign s.hs_out      = r_dly_hs[3];
  assign s.vs_out      = r_dly_vs[3];

endmodule
`default_nettype wire
